// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, BCD limits and 7-segment decode for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_TENS_S_MAX = 4'd5;
    localparam logic [3:0] PRESCALE_MAX   = 4'd9;

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - button synchroniser, ms-based debounce and press pulse
module button_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic btn,
    output logic press
);

    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_MS);

    logic       sync_a;
    logic       sync_b;
    logic       stable;
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= 8'd0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == stable) begin
                cnt <= 8'd0;
            end else if (ms_tick) begin
                // Only a 0->1 acceptance produces an event; releases are silent.
                if (cnt == LIMIT - 8'd1) begin
                    stable <= sync_b;
                    cnt    <= 8'd0;
                    press  <= sync_b;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - SS.hh stopwatch with debounced buttons and 4-digit 7-segment scan
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_MS    = 20,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Clk_1kHz,
    input  logic        Btn_StartStop,
    input  logic        Btn_Clear,
    output logic        Running,
    output logic [15:0] Time_BCD,
    output logic        Overflow,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  Digit_En
);

    localparam logic POL = SEG_ACTIVE_LOW;

    logic        tick_sync_a;
    logic        tick_sync_b;
    logic        tick_hist;
    logic        ms_tick;
    logic        start_ev;
    logic        clear_ev;
    state_t      state;
    logic [3:0]  prescaler;
    logic [15:0] time_q;
    logic [15:0] next_time;
    logic        wrap;
    logic [1:0]  scan_idx;
    logic        disp_on;
    logic [3:0]  digit;
    logic [6:0]  seg_ah;
    logic [3:0]  en_ah;
    logic        dp_ah;

    // Clk_1kHz is data here: synchronise, then pulse on its rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_sync_a <= 1'b0;
            tick_sync_b <= 1'b0;
            tick_hist   <= 1'b0;
        end else begin
            tick_sync_a <= Clk_1kHz;
            tick_sync_b <= tick_sync_a;
            tick_hist   <= tick_sync_b;
        end
    end

    assign ms_tick = tick_sync_b & ~tick_hist;

    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
        .clk     (Clk),
        .rst     (Reset),
        .ms_tick (ms_tick),
        .btn     (Btn_StartStop),
        .press   (start_ev)
    );

    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clear (
        .clk     (Clk),
        .rst     (Reset),
        .ms_tick (ms_tick),
        .btn     (Btn_Clear),
        .press   (clear_ev)
    );

    always_comb begin
        next_time = time_q;
        wrap      = 1'b0;
        if (time_q[3:0] != BCD_DIGIT_MAX) begin
            next_time[3:0] = time_q[3:0] + 4'd1;
        end else begin
            next_time[3:0] = 4'd0;
            if (time_q[7:4] != BCD_DIGIT_MAX) begin
                next_time[7:4] = time_q[7:4] + 4'd1;
            end else begin
                next_time[7:4] = 4'd0;
                if (time_q[11:8] != BCD_DIGIT_MAX) begin
                    next_time[11:8] = time_q[11:8] + 4'd1;
                end else begin
                    next_time[11:8] = 4'd0;
                    if (time_q[15:12] != BCD_TENS_S_MAX) begin
                        next_time[15:12] = time_q[15:12] + 4'd1;
                    end else begin
                        next_time[15:12] = 4'd0;
                        wrap             = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Running   <= 1'b0;
            prescaler <= 4'd0;
            time_q    <= 16'h0000;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    prescaler <= 4'd0;
                    if (start_ev) begin
                        state   <= ST_RUN;
                        Running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ms_tick) begin
                        if (prescaler == PRESCALE_MAX) begin
                            prescaler <= 4'd0;
                            time_q    <= next_time;
                            if (wrap) begin
                                Overflow <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 4'd1;
                        end
                    end
                    if (start_ev) begin
                        state   <= ST_PAUSED;
                        Running <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    // Clear takes priority over a simultaneous start here.
                    if (clear_ev) begin
                        state     <= ST_IDLE;
                        prescaler <= 4'd0;
                        time_q    <= 16'h0000;
                        Overflow  <= 1'b0;
                    end else if (start_ev) begin
                        state   <= ST_RUN;
                        Running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    Running <= 1'b0;
                end
            endcase
        end
    end

    assign Time_BCD = time_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scan_idx <= 2'd0;
            disp_on  <= 1'b0;
        end else if (ms_tick) begin
            scan_idx <= scan_idx + 2'd1;
            disp_on  <= 1'b1;
        end
    end

    always_comb begin
        case (scan_idx)
            2'd0:    digit = time_q[3:0];
            2'd1:    digit = time_q[7:4];
            2'd2:    digit = time_q[11:8];
            default: digit = time_q[15:12];
        endcase
        seg_ah = seg_decode(digit);
        en_ah  = 4'b0001 << scan_idx;
        dp_ah  = (scan_idx == 2'd2);
    end

    // Drive levels are XORed with POL so "inactive" is all-zero active-high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Seg      <= {7{POL}};
            Dp       <= POL;
            Digit_En <= {4{POL}};
        end else if (!disp_on) begin
            Seg      <= {7{POL}};
            Dp       <= POL;
            Digit_En <= {4{POL}};
        end else begin
            Seg      <= seg_ah ^ {7{POL}};
            Dp       <= dp_ah ^ POL;
            Digit_En <= en_ah ^ {4{POL}};
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - directed self-checking bench for stopwatch_display
module tb_stopwatch_display;

    logic        clk;
    logic        rst;
    logic        clk_1k;
    logic        start_a, clear_a;
    logic        running_a, ovf_a, dp_a;
    logic [15:0] time_a;
    logic [6:0]  seg_a;
    logic [3:0]  en_a;
    logic        start_b, clear_b;
    logic        running_b, ovf_b, dp_b;
    logic [15:0] time_b;
    logic [6:0]  seg_b;
    logic [3:0]  en_b;

    int n_checks = 0;
    int n_fail   = 0;
    int run_rises = 0;

    typedef struct {
        logic [3:0] digit_en;
        logic [6:0] seg;
        logic       dp;
    } scan_vec_t;

    typedef struct {
        logic [3:0] digit;
        logic [6:0] seg;
    } dec_vec_t;

    scan_vec_t scan_tbl[4];
    dec_vec_t  dec_tbl[10];

    stopwatch_display #(.DEBOUNCE_MS(4), .SEG_ACTIVE_LOW(1'b1)) u_dut (
        .Clk           (clk),
        .Reset         (rst),
        .Clk_1kHz      (clk_1k),
        .Btn_StartStop (start_a),
        .Btn_Clear     (clear_a),
        .Running       (running_a),
        .Time_BCD      (time_a),
        .Overflow      (ovf_a),
        .Seg           (seg_a),
        .Dp            (dp_a),
        .Digit_En      (en_a)
    );

    stopwatch_display #(.DEBOUNCE_MS(20), .SEG_ACTIVE_LOW(1'b1)) u_dut20 (
        .Clk           (clk),
        .Reset         (rst),
        .Clk_1kHz      (clk_1k),
        .Btn_StartStop (start_b),
        .Btn_Clear     (clear_b),
        .Running       (running_b),
        .Time_BCD      (time_b),
        .Overflow      (ovf_b),
        .Seg           (seg_b),
        .Dp            (dp_b),
        .Digit_En      (en_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk_1k = 1'b0;
        #3;
        forever #100 clk_1k = ~clk_1k;
    end

    always @(posedge running_a) run_rises++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk_1k);
        repeat (5) @(negedge clk);
    endtask

    task automatic press_a(input logic s, input logic c);
        start_a = s;
        clear_a = c;
        wait_ticks(4);
        start_a = 1'b0;
        clear_a = 1'b0;
    endtask

    task automatic preload_a(input logic [15:0] t, input logic [3:0] p);
        force u_dut.time_q = t;
        force u_dut.prescaler = p;
        #1;
        release u_dut.time_q;
        release u_dut.prescaler;
    endtask

    initial begin
        int guard;
        scan_tbl[0] = '{4'b1110, 7'h19, 1'b1};
        scan_tbl[1] = '{4'b1101, 7'h30, 1'b1};
        scan_tbl[2] = '{4'b1011, 7'h24, 1'b0};
        scan_tbl[3] = '{4'b0111, 7'h79, 1'b1};
        dec_tbl[0] = '{4'd0, 7'h40};
        dec_tbl[1] = '{4'd1, 7'h79};
        dec_tbl[2] = '{4'd2, 7'h24};
        dec_tbl[3] = '{4'd3, 7'h30};
        dec_tbl[4] = '{4'd4, 7'h19};
        dec_tbl[5] = '{4'd5, 7'h12};
        dec_tbl[6] = '{4'd6, 7'h02};
        dec_tbl[7] = '{4'd7, 7'h78};
        dec_tbl[8] = '{4'd8, 7'h00};
        dec_tbl[9] = '{4'd9, 7'h10};

        rst = 1'b0;
        start_a = 1'b0; clear_a = 1'b0;
        start_b = 1'b0; clear_b = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_running", running_a, 1'b0);
        check("reset_time", time_a, 16'h0000);
        check("reset_overflow", ovf_a, 1'b0);
        check("reset_seg", seg_a, 7'h7F);
        check("reset_dp", dp_a, 1'b1);
        check("reset_digit_en", en_a, 4'hF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("pretick_digit_en", en_a, 4'hF);

        // Reset asserted mid-run at 00.57 acts without a clock edge
        press_a(1'b1, 1'b0);
        check("s1_running", running_a, 1'b1);
        guard = 0;
        while (time_a !== 16'h0057 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("s1_reach_0057", time_a, 16'h0057);
        #2 rst = 1'b1;
        #1;
        check("s1_async_running", running_a, 1'b0);
        check("s1_async_time", time_a, 16'h0000);
        check("s1_async_digit_en", en_a, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ticks(2);

        // Bouncing start press yields one event
        run_rises = 0;
        start_a = 1'b1; wait_ticks(1);
        start_a = 1'b0; wait_ticks(1);
        start_a = 1'b1; wait_ticks(1);
        check("s3_bounce_idle", running_a, 1'b0);
        wait_ticks(10);
        start_a = 1'b0;
        wait_ticks(6);
        check("s3_running", running_a, 1'b1);
        check("s3_one_event", run_rises, 1);

        // Clear in RUN ignored; wrap 59.99 -> 00.00 sets Overflow
        press_a(1'b0, 1'b1);
        check("s4_clear_ignored", running_a, 1'b1);
        wait_ticks(5);
        press_a(1'b1, 1'b0);
        check("s4_paused", running_a, 1'b0);
        wait_ticks(5);
        preload_a(16'h5999, 4'd0);
        press_a(1'b1, 1'b0);
        check("s4_resumed", running_a, 1'b1);
        check("s4_preload", time_a, 16'h5999);
        wait_ticks(9);
        check("s4_before_wrap", time_a, 16'h5999);
        check("s4_no_ovf_yet", ovf_a, 1'b0);
        wait_ticks(1);
        check("s4_wrap_time", time_a, 16'h0000);
        check("s4_wrap_ovf", ovf_a, 1'b1);
        check("s4_wrap_running", running_a, 1'b1);
        wait_ticks(10);
        check("s4_count_on", time_a, 16'h0001);
        check("s4_ovf_sticky", ovf_a, 1'b1);
        press_a(1'b1, 1'b0);
        wait_ticks(5);
        press_a(1'b0, 1'b1);
        check("s4_idle_running", running_a, 1'b0);
        check("s4_idle_time", time_a, 16'h0000);
        check("s4_idle_ovf", ovf_a, 1'b0);
        wait_ticks(5);

        // Pause holds prescaler; start+clear priority
        press_a(1'b1, 1'b0);
        wait_ticks(5);
        press_a(1'b1, 1'b0);
        wait_ticks(5);
        preload_a(16'h0003, 4'd6);
        wait_ticks(500);
        check("s5_frozen", time_a, 16'h0003);
        press_a(1'b1, 1'b0);
        check("s5_resumed", running_a, 1'b1);
        wait_ticks(3);
        check("s5_three_ticks", time_a, 16'h0003);
        wait_ticks(1);
        check("s5_four_ticks", time_a, 16'h0004);
        wait_ticks(1);
        press_a(1'b1, 1'b0);
        check("s5_paused", running_a, 1'b0);
        wait_ticks(5);
        press_a(1'b1, 1'b1);
        check("s5_both_paused_running", running_a, 1'b0);
        check("s5_both_paused_time", time_a, 16'h0000);
        wait_ticks(5);
        press_a(1'b1, 1'b1);
        check("s5_both_idle_running", running_a, 1'b1);
        wait_ticks(5);
        press_a(1'b1, 1'b0);
        wait_ticks(5);

        // Display scan of 12.34 while paused
        preload_a(16'h1234, 4'd0);
        guard = 0;
        while (en_a !== 4'b1110 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_ticks(1);
            check($sformatf("s6_digit_en_%0d", i), en_a, scan_tbl[i].digit_en);
            check($sformatf("s6_seg_%0d", i), seg_a, scan_tbl[i].seg);
            check($sformatf("s6_dp_%0d", i), dp_a, scan_tbl[i].dp);
        end
        for (int d = 0; d < 10; d++) begin
            preload_a({4{dec_tbl[d].digit}}, 4'd0);
            wait_ticks(1);
            check($sformatf("decode_%0d", d), seg_a, dec_tbl[d].seg);
        end

        // 20 ms debounce instance
        start_b = 1'b1;
        wait_ticks(19);
        check("s2_not_yet", running_b, 1'b0);
        wait_ticks(1);
        check("s2_running", running_b, 1'b1);
        wait_ticks(10);
        check("s2_time_0001", time_b, 16'h0001);
        start_b = 1'b0;
        wait_ticks(989);
        check("s2_time_0099", time_b, 16'h0099);
        wait_ticks(1);
        check("s2_time_0100", time_b, 16'h0100);
        check("s2_still_running", running_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
